// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with an internal accumulator and valid/ready handshakes.
// Define ALU_PIPE_CV_FLAGS_EN to build the registered carry/overflow flags; otherwise cy/ov are 0.
module alu_pipe #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       s,
    input  logic             acc_sel,
    input  logic             acc_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov,
    output logic [WIDTH-1:0] acc
);

    // Stage 1 operand registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [5:0]       s_q;
    logic             acc_sel_q;
    logic             acc_we_q;

    // Stage 2 result registers and accumulator
    logic             out_valid_q;
    logic [WIDTH-1:0] c_q;
    logic             zr_q;
    logic             ng_q;
    logic [WIDTH-1:0] acc_q;

    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] c_next;

    assign advance  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        x = acc_sel_q ? acc_q : a_q;
        if (s_q[5]) x = '0;
        if (s_q[4]) x = ~x;
        y = b_q;
        if (s_q[3]) y = '0;
        if (s_q[2]) y = ~y;
        r      = s_q[1] ? sum : (x & y);
        c_next = s_q[0] ? ~r : r;
    end

`ifdef ALU_PIPE_CV_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic           cy_next;
    logic           ov_next;
    logic           cy_q;
    logic           ov_q;

    assign sum_ext = {1'b0, x} + {1'b0, y};
    assign sum     = sum_ext[WIDTH-1:0];
    // Flags come from the raw adder, before output negation; AND ops report none.
    assign cy_next = s_q[1] && sum_ext[WIDTH];
    assign ov_next = s_q[1] && (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cy_q <= 1'b0;
            ov_q <= 1'b0;
        end else if (advance) begin
            cy_q <= cy_next;
            ov_q <= ov_next;
        end
    end

    assign cy = cy_q;
    assign ov = ov_q;
`else
    assign sum = x + y;
    assign cy  = 1'b0;
    assign ov  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            acc_sel_q  <= 1'b0;
            acc_we_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q       <= a;
                b_q       <= b;
                s_q       <= s;
                acc_sel_q <= acc_sel;
                acc_we_q  <= acc_we;
            end
            if (accept) begin
                s1_valid_q <= 1'b1;
            end else if (advance) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
        end else if (advance) begin
            out_valid_q <= 1'b1;
            c_q         <= c_next;
            zr_q        <= (c_next == '0);
            ng_q        <= c_next[WIDTH-1];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Updating on the transfer edge lets the next acc_sel op in S1 see it without a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= ACC_INIT;
        end else if (advance && acc_we_q) begin
            acc_q <= c_next;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized scoreboard bench for alu_pipe against a behavioural ALU model.
// Build with ALU_PIPE_CV_FLAGS_EN defined to expect carry/overflow flags.
module tb_alu_pipe;

    localparam int W = 16;
    localparam logic [W-1:0] ACC_INIT = 16'h0A5A;

    typedef struct packed {
        logic [W-1:0] c;
        logic         zr;
        logic         ng;
        logic         cy;
        logic         ov;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [5:0]   s = '0;
    logic         acc_sel = 1'b0;
    logic         acc_we = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] c;
    logic         zr;
    logic         ng;
    logic         cy;
    logic         ov;
    logic [W-1:0] acc;

    res_t         exp_q[$];
    logic [W-1:0] model_acc;
    int           vectors = 0;
    int           miscompares = 0;
    logic         rand_rdy = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH    (W),
        .ACC_INIT (ACC_INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .acc_sel   (acc_sel),
        .acc_we    (acc_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zr        (zr),
        .ng        (ng),
        .cy        (cy),
        .ov        (ov),
        .acc       (acc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the control-word rules.
    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                   input logic [5:0] ts, input logic tsel);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        int unsigned  usum;
        res_t         o;
        x = tsel ? model_acc : ta;
        if (ts[5]) x = '0;
        if (ts[4]) x = ~x;
        y = tb_v;
        if (ts[3]) y = '0;
        if (ts[2]) y = ~y;
        o.cy = 1'b0;
        o.ov = 1'b0;
        if (ts[1]) begin
            usum = int'(x) + int'(y);
            r = usum[W-1:0];
`ifdef ALU_PIPE_CV_FLAGS_EN
            begin
                int ssum;
                ssum = int'($signed(x)) + int'($signed(y));
                o.cy = (usum > 32'hFFFF);
                o.ov = (ssum > 32767) || (ssum < -32768);
            end
`endif
        end else begin
            r = x & y;
        end
        o.c  = ts[0] ? ~r : r;
        o.zr = (o.c == '0);
        o.ng = o.c[W-1];
        return o;
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic try_send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [5:0] ts,
                            input logic tsel, input logic twe, output logic ok);
        res_t e;
        a = ta;
        b = tb_v;
        s = ts;
        acc_sel = tsel;
        acc_we = twe;
        in_valid = 1'b1;
        @(negedge clk);
        ok = in_ready;
        if (ok) begin
            e = model(ta, tb_v, ts, tsel);
            exp_q.push_back(e);
            if (twe) model_acc = e.c;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [5:0] ts,
                        input logic tsel, input logic twe);
        logic ok;
        int   n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            try_send(ta, tb_v, ts, tsel, twe, ok);
            n++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every output handshake, checks held outputs under stall.
    logic held = 1'b0;
    res_t held_v;
    always @(negedge clk) begin
        res_t got;
        res_t e;
        got = {c, zr, ng, cy, ov};
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", got, held_v);
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("c", got.c, e.c);
                    check("zr", got.zr, e.zr);
                    check("ng", got.ng, e.ng);
                    check("cy", got.cy, e.cy);
                    check("ov", got.ov, e.ov);
                end
            end else if (out_valid) begin
                held = 1'b1;
                held_v = got;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   k;
        model_acc = ACC_INIT;

        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_flags", {zr, ng, cy, ov}, 0);
        check("rst_acc", acc, ACC_INIT);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        // ADD with exact latency
        try_send(16'd5, 16'd7, 6'b000010, 1'b0, 1'b0, ok);
        check("add_accept", ok, 1);
        @(negedge clk);
        check("add_lat_early", out_valid, 0);
        @(negedge clk);
        check("add_lat_valid", out_valid, 1);
        check("add_c", c, 12);
        @(posedge clk);
        #1;

        send(16'd3, 16'd5, 6'b010011, 1'b0, 1'b0);
        send(16'h1234, 16'h4321, 6'b101010, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 6'b000010, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 6'b000010, 1'b0, 1'b0);
        drain();

        // Accumulator: load 10 then three back-to-back increments
        send(16'd10, 16'd0, 6'b001100, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            try_send(16'd0, 16'd1, 6'b000010, 1'b1, 1'b1, ok);
            check("acc_b2b_accept", ok, 1);
        end
        drain();
        check("acc_final", acc, 13);

        // Backpressure: only two ops fit while the output is stalled
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            try_send(W'(k * 1000 + 3), W'(100 + k), 6'b000010, 1'b0, 1'b0, ok);
            if (ok) k++;
        end
        check("bp_accepted", k, 2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_c", c, 103);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int j = k; j < 4; j++) send(W'(j * 1000 + 3), W'(100 + j), 6'b000010, 1'b0, 1'b0);
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        try_send(16'd3, 16'd4, 6'b000010, 1'b0, 1'b1, ok);
        try_send(16'd8, 16'd9, 6'b000010, 1'b0, 1'b1, ok);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_acc", acc, ACC_INIT);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        model_acc = ACC_INIT;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'd0, 16'd4, 6'b000010, 1'b1, 1'b0);
        drain();

        // Randomized traffic with random output backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(pick(), pick(), 6'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();
        check("final_acc", acc, model_acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
